// File: rtl/vector_pkg.sv
// Shared types for the vector unit: VALU opcodes, register tags
// and the sequencer state encoding.
package vector_pkg;

    typedef enum logic [5:0] {
        VALU_ADD  = 6'h00,
        VALU_SUB  = 6'h01,
        VALU_MIN  = 6'h02,
        VALU_MAX  = 6'h03,
        VALU_MINU = 6'h04,
        VALU_MAXU = 6'h05,
        VALU_AND  = 6'h06,
        VALU_OR   = 6'h07,
        VALU_XOR  = 6'h08,
        VALU_SLL  = 6'h09,
        VALU_SRL  = 6'h0A,
        VALU_SRA  = 6'h0B
    } valu_op_t;

    localparam logic [5:0] VALU_OP_MAX = 6'h0B;

    typedef logic [7:0] vreg_t;

    typedef enum logic {
        VSEQ_IDLE,
        VSEQ_STREAM
    } vseq_state_t;

endpackage

// File: rtl/vector_lane_alu.sv
// One combinational VALU lane; disabled or illegal lanes
// produce zero.
module vector_lane_alu
    import vector_pkg::*;
#(
    parameter int ELEM_W = 16
) (
    input  logic [ELEM_W-1:0] a,
    input  logic [ELEM_W-1:0] b,
    input  logic [5:0]        op,
    input  logic              en,
    output logic [ELEM_W-1:0] result,
    output logic              illegal
);

    localparam int SH_W = (ELEM_W > 1) ? $clog2(ELEM_W) : 1;

    logic [SH_W-1:0]   sh;
    logic [ELEM_W-1:0] r;

    assign sh = b[SH_W-1:0];

    always_comb begin
        r = '0;
        case (op)
            VALU_ADD:  r = a + b;
            VALU_SUB:  r = a - b;
            VALU_MIN:  r = ($signed(a) < $signed(b)) ? a : b;
            VALU_MAX:  r = ($signed(a) > $signed(b)) ? a : b;
            VALU_MINU: r = (a < b) ? a : b;
            VALU_MAXU: r = (a > b) ? a : b;
            VALU_AND:  r = a & b;
            VALU_OR:   r = a | b;
            VALU_XOR:  r = a ^ b;
            VALU_SLL:  r = a << sh;
            VALU_SRL:  r = a >> sh;
            VALU_SRA:  r = ELEM_W'($signed(a) >>> sh);
            default:   r = '0;
        endcase
    end

    assign illegal = (op > VALU_OP_MAX);
    assign result  = (en && !illegal) ? r : '0;

endmodule

// File: rtl/vector_valu_seq.sv
// Multi-beat vector ALU: latches one vector op and streams
// VLEN/LANES registered result beats with backpressure.
module vector_valu_seq
    import vector_pkg::*;
#(
    parameter int VLEN   = 32,
    parameter int LANES  = 8,
    parameter int ELEM_W = 16,
    localparam int NB     = VLEN / LANES,
    localparam int BEAT_W = (NB > 1) ? $clog2(NB) : 1
) (
    input  logic                      CLK,
    input  logic                      nRST,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [5:0]                req_op,
    input  logic [VLEN*ELEM_W-1:0]    req_vs1,
    input  logic [VLEN*ELEM_W-1:0]    req_vs2,
    input  logic                      req_masked,
    input  logic [VLEN-1:0]           req_vmask,
    input  logic [7:0]                req_vd,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*ELEM_W-1:0]   out_data,
    output logic [LANES-1:0]          out_wen,
    output logic [BEAT_W-1:0]         out_beat,
    output logic [7:0]                out_vd,
    output logic                      out_last,
    output logic                      out_err
);

    localparam int VW = VLEN * ELEM_W;
    localparam int LW = LANES * ELEM_W;
    localparam logic [BEAT_W-1:0] LAST = BEAT_W'(NB - 1);

    vseq_state_t       state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [VW-1:0]     vs1_q, vs2_q;
    logic [VLEN-1:0]   mask_q;
    logic [5:0]        op_q;
    vreg_t             vd_q;
    logic [LW-1:0]     data_q;
    logic [LANES-1:0]  wen_q;
    logic              err_q;
    logic              capture, load;

    logic [VW-1:0]     src1, src2;
    logic [VLEN-1:0]   src_m;
    logic [5:0]        src_op;
    logic [BEAT_W:0]   nxt;
    int                idx;

    logic [ELEM_W-1:0] la [LANES];
    logic [ELEM_W-1:0] lb [LANES];
    logic [LANES-1:0]  len;
    logic [LANES-1:0]  ill;
    logic [LANES-1:0]  wen;
    logic [LW-1:0]     res;

    // In IDLE the lanes see the request directly so beat 0 is
    // ready on the accept edge; afterwards they look one beat ahead.
    always_comb begin
        idx = 0;
        if (state_q == VSEQ_IDLE) begin
            src1   = req_vs1;
            src2   = req_vs2;
            src_m  = req_masked ? req_vmask : '1;
            src_op = req_op;
            nxt    = '0;
        end else begin
            src1   = vs1_q;
            src2   = vs2_q;
            src_m  = mask_q;
            src_op = op_q;
            nxt    = {1'b0, beat_q} + 1'b1;
        end
        for (int l = 0; l < LANES; l++) begin
            la[l]  = '0;
            lb[l]  = '0;
            len[l] = 1'b0;
            idx    = int'(nxt) * LANES + l;
            if (idx < VLEN) begin
                la[l]  = src1[idx*ELEM_W +: ELEM_W];
                lb[l]  = src2[idx*ELEM_W +: ELEM_W];
                len[l] = src_m[idx];
            end
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        vector_lane_alu #(
            .ELEM_W (ELEM_W)
        ) u_lane (
            .a       (la[g]),
            .b       (lb[g]),
            .op      (src_op),
            .en      (len[g]),
            .result  (res[g*ELEM_W +: ELEM_W]),
            .illegal (ill[g])
        );
        assign wen[g] = len[g] & ~ill[g];
    end

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        capture   = 1'b0;
        load      = 1'b0;
        req_ready = 1'b0;
        unique case (state_q)
            VSEQ_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_d = VSEQ_STREAM;
                    beat_d  = '0;
                    capture = 1'b1;
                    load    = 1'b1;
                end
            end
            VSEQ_STREAM: begin
                if (out_ready) begin
                    if (beat_q == LAST) begin
                        state_d = VSEQ_IDLE;
                    end else begin
                        beat_d = beat_q + 1'b1;
                        load   = 1'b1;
                    end
                end
            end
            default: state_d = VSEQ_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= VSEQ_IDLE;
            beat_q  <= '0;
            vs1_q   <= '0;
            vs2_q   <= '0;
            mask_q  <= '0;
            op_q    <= '0;
            vd_q    <= '0;
            data_q  <= '0;
            wen_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            if (capture) begin
                vs1_q  <= req_vs1;
                vs2_q  <= req_vs2;
                mask_q <= src_m;
                op_q   <= req_op;
                vd_q   <= req_vd;
            end
            if (load) begin
                data_q <= res;
                wen_q  <= wen;
                err_q  <= |ill;
            end
        end
    end

    assign out_valid = (state_q == VSEQ_STREAM);
    assign out_data  = data_q;
    assign out_wen   = wen_q;
    assign out_err   = err_q;
    assign out_beat  = beat_q;
    assign out_vd    = vd_q;
    assign out_last  = out_valid && (beat_q == LAST);

endmodule
